// File: rtl/elevator_car_ctrl_if.sv
// Interface bundling the hall-call/car-destination inputs and the car status
// outputs of the elevator car controller.
// master: request/status side (call decoder, passenger-queue logic)
// slave : the car controller itself
interface elevator_car_ctrl_if;
    logic [6:0] up_passenger;
    logic [6:0] down_passenger;
    logic [6:0] car_dest;
    logic       door_hold;
    logic [2:0] cur_floor;
    logic       moving_up;
    logic       moving_down;
    logic       door_open;
    logic [6:0] served_floor;
    logic       served_up;
    logic       served_dn;

    modport master (
        output up_passenger, down_passenger, car_dest, door_hold,
        input  cur_floor, moving_up, moving_down, door_open,
        input  served_floor, served_up, served_dn
    );

    modport slave (
        input  up_passenger, down_passenger, car_dest, door_hold,
        output cur_floor, moving_up, moving_down, door_open,
        output served_floor, served_up, served_dn
    );
endinterface

// File: rtl/elevator_car_ctrl.sv
// Car-motion controller for a 7-floor elevator: LOOK scheduling over the
// up/down hall-call masks and the in-car destination mask, per-floor travel
// timing, door dwell with hold, and one-cycle "served" pulses for the
// passenger-queue logic.
// Optional feature: define PARK_HOME_EN to return an idle car to floor 1
// after PARK_CYCLES consecutive idle cycles.
module elevator_car_ctrl #(
    parameter int MOVE_CYCLES = 8,
    parameter int DOOR_CYCLES = 4,
    parameter int CNT_W       = 8
`ifdef PARK_HOME_EN
    , parameter int PARK_CYCLES = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    elevator_car_ctrl_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_MOVE_UP, S_MOVE_DN, S_DOOR} state_t;

    localparam logic [CNT_W-1:0] MOVE_RELOAD = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_RELOAD = CNT_W'(DOOR_CYCLES - 1);

    function automatic logic [6:0] f_onehot(input logic [2:0] f);
        f_onehot = 7'd1 << (f - 3'd1);
    endfunction

    // floors strictly above f
    function automatic logic [6:0] f_above(input logic [2:0] f);
        f_above = 7'h7f << f;
    endfunction

    // floors strictly below f
    function automatic logic [6:0] f_below(input logic [2:0] f);
        f_below = ~(7'h7f << (f - 3'd1));
    endfunction

    state_t           r_state, w_state_nx;
    logic [2:0]       r_floor, w_floor_nx;
    logic             r_dir,   w_dir_nx;     // 1 = up
    logic [CNT_W-1:0] r_timer, w_timer_nx;
    logic [6:0]       r_srv_floor, w_srv_floor_nx;
    logic             r_srv_up, w_srv_up_nx;
    logic             r_srv_dn, w_srv_dn_nx;
`ifdef PARK_HOME_EN
    logic [CNT_W-1:0] r_park_cnt, w_park_cnt_nx;
    logic             r_parking,  w_parking_nx;
`endif

    logic [6:0] w_up, w_dn, w_car, w_req;
    logic       w_here, w_above, w_below;
    logic [2:0] w_sf;          // floor being evaluated for a stop/serve
    logic [6:0] w_sf_oh;
    logic       w_sf_beyond, w_sf_stop;
    logic       w_match, w_flip, w_serve_up, w_serve_dn;

    // request masks and the stop/serve decision for the evaluated floor
    always_comb begin
        w_up    = bus.up_passenger & 7'b0111111;
        w_dn    = bus.down_passenger & 7'b1111110;
        w_car   = bus.car_dest;
        w_req   = w_up | w_dn | w_car;
        w_here  = |(w_req & f_onehot(r_floor));
        w_above = |(w_req & f_above(r_floor));
        w_below = |(w_req & f_below(r_floor));
        // IDLE serves the current floor; a moving car evaluates the floor it is arriving at
        if (r_state == S_MOVE_UP)      w_sf = r_floor + 3'd1;
        else if (r_state == S_MOVE_DN) w_sf = r_floor - 3'd1;
        else                           w_sf = r_floor;
        w_sf_oh     = f_onehot(w_sf);
        w_sf_beyond = r_dir ? |(w_req & f_above(w_sf)) : |(w_req & f_below(w_sf));
        w_sf_stop   = |(w_car & w_sf_oh)
                    | (r_dir ? |(w_up & w_sf_oh) : |(w_dn & w_sf_oh))
                    | (!w_sf_beyond && |(w_req & w_sf_oh));
        w_match     = r_dir ? |(w_up & w_sf_oh) : |(w_dn & w_sf_oh);
        // nothing in the travel direction: turn around and board the opposite call
        w_flip      = !w_match && !w_sf_beyond;
        w_serve_up  = (r_dir && w_match) || (!r_dir && w_flip && |(w_up & w_sf_oh));
        w_serve_dn  = (!r_dir && w_match) || (r_dir && w_flip && |(w_dn & w_sf_oh));
    end

    // next-state logic for the LOOK scheduler, timers and served pulses
    always_comb begin
        w_state_nx     = r_state;
        w_floor_nx     = r_floor;
        w_dir_nx       = r_dir;
        w_timer_nx     = r_timer;
        w_srv_floor_nx = 7'd0;
        w_srv_up_nx    = 1'b0;
        w_srv_dn_nx    = 1'b0;
`ifdef PARK_HOME_EN
        w_park_cnt_nx  = '0;
        w_parking_nx   = r_parking;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_here) begin
                    w_state_nx     = S_DOOR;
                    w_timer_nx     = DOOR_RELOAD;
                    w_srv_floor_nx = w_sf_oh;
                    w_srv_up_nx    = w_serve_up;
                    w_srv_dn_nx    = w_serve_dn;
                    if (w_flip) w_dir_nx = ~r_dir;
                end else if ((r_dir && w_above) || (!r_dir && w_below)) begin
                    w_state_nx = r_dir ? S_MOVE_UP : S_MOVE_DN;
                    w_timer_nx = MOVE_RELOAD;
                end else if (w_above) begin
                    w_dir_nx   = 1'b1;
                    w_state_nx = S_MOVE_UP;
                    w_timer_nx = MOVE_RELOAD;
                end else if (w_below) begin
                    w_dir_nx   = 1'b0;
                    w_state_nx = S_MOVE_DN;
                    w_timer_nx = MOVE_RELOAD;
                end
`ifdef PARK_HOME_EN
                else if (r_floor != 3'd1) begin
                    if (r_park_cnt == CNT_W'(PARK_CYCLES - 1)) begin
                        w_dir_nx     = 1'b0;
                        w_state_nx   = S_MOVE_DN;
                        w_timer_nx   = MOVE_RELOAD;
                        w_parking_nx = 1'b1;
                    end else begin
                        w_park_cnt_nx = r_park_cnt + CNT_W'(1);
                    end
                end
`endif
            end
            S_MOVE_UP, S_MOVE_DN: begin
                if (r_timer != '0) begin
                    w_timer_nx = r_timer - CNT_W'(1);
                end else begin
                    w_floor_nx = w_sf;
                    if (w_sf_stop) begin
                        w_state_nx     = S_DOOR;
                        w_timer_nx     = DOOR_RELOAD;
                        w_srv_floor_nx = w_sf_oh;
                        w_srv_up_nx    = w_serve_up;
                        w_srv_dn_nx    = w_serve_dn;
                        if (w_flip) w_dir_nx = ~r_dir;
`ifdef PARK_HOME_EN
                        w_parking_nx   = 1'b0;
`endif
                    end else if (w_sf_beyond) begin
                        w_timer_nx = MOVE_RELOAD;
                    end
`ifdef PARK_HOME_EN
                    else if (r_parking && (w_req == 7'd0) && (w_sf != 3'd1)) begin
                        w_timer_nx = MOVE_RELOAD;
                    end
`endif
                    else begin
                        w_state_nx = S_IDLE;
`ifdef PARK_HOME_EN
                        w_parking_nx = 1'b0;
`endif
                    end
                end
            end
            S_DOOR: begin
                if (bus.door_hold)        w_timer_nx = DOOR_RELOAD;
                else if (r_timer == '0)   w_state_nx = S_IDLE;
                else                      w_timer_nx = r_timer - CNT_W'(1);
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_floor     <= 3'd1;
            r_dir       <= 1'b1;
            r_timer     <= '0;
            r_srv_floor <= 7'd0;
            r_srv_up    <= 1'b0;
            r_srv_dn    <= 1'b0;
`ifdef PARK_HOME_EN
            r_park_cnt  <= '0;
            r_parking   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_floor     <= w_floor_nx;
            r_dir       <= w_dir_nx;
            r_timer     <= w_timer_nx;
            r_srv_floor <= w_srv_floor_nx;
            r_srv_up    <= w_srv_up_nx;
            r_srv_dn    <= w_srv_dn_nx;
`ifdef PARK_HOME_EN
            r_park_cnt  <= w_park_cnt_nx;
            r_parking   <= w_parking_nx;
`endif
        end
    end

    assign bus.cur_floor    = r_floor;
    assign bus.moving_up    = (r_state == S_MOVE_UP);
    assign bus.moving_down  = (r_state == S_MOVE_DN);
    assign bus.door_open    = (r_state == S_DOOR);
    assign bus.served_floor = r_srv_floor;
    assign bus.served_up    = r_srv_up;
    assign bus.served_dn    = r_srv_dn;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed testbench for elevator_car_ctrl (default parameters:
// MOVE_CYCLES=8, DOOR_CYCLES=4, PARK_CYCLES=16).
module tb_elevator_car_ctrl;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    elevator_car_ctrl_if bus ();

    elevator_car_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0 = moving_up, 1 = moving_down, 2 = door_open
    function automatic logic flag(input int which);
        case (which)
            0:       flag = bus.moving_up;
            1:       flag = bus.moving_down;
            default: flag = bus.door_open;
        endcase
    endfunction

    // wait (bounded) for a status flag to be observed high at a falling edge
    task automatic wait_high(input int which, input int limit, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!flag(which) && waited < limit);
    endtask

    // count consecutive falling edges with the flag high, starting at the current one
    task automatic measure(input int which, input int limit, output int n);
        n = 0;
        while (flag(which) && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.up_passenger   = 7'd0;
        bus.down_passenger = 7'd0;
        bus.car_dest       = 7'd0;
        bus.door_hold      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int  w;
        int  n;
        logic bad;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.up_passenger   = 7'd0;
        bus.down_passenger = 7'd0;
        bus.car_dest       = 7'd0;
        bus.door_hold      = 1'b0;

        // ---- 1: reset state, then 50 idle cycles with no requests
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_floor", bus.cur_floor, 3'd1);
        chk("rst_flags", {bus.moving_up, bus.moving_down, bus.door_open}, 3'b000);
        chk("rst_served", {bus.served_floor, bus.served_up, bus.served_dn}, 9'd0);
        reset = 1'b0;
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (bus.cur_floor != 3'd1 || bus.moving_up || bus.moving_down || bus.door_open)
                bad = 1'b1;
        end
        chk("idle50_nochange", bad, 1'b0);

        // ---- 2: up call at floor 4 from floor 1
        bus.up_passenger = 7'b0001000;
        wait_high(0, 5, w);
        chk("t2_start_latency", w, 1);
        measure(0, 100, n);
        chk("t2_move_cycles", n, 24);
        chk("t2_floor", bus.cur_floor, 3'd4);
        chk("t2_door", bus.door_open, 1'b1);
        chk("t2_served_floor", bus.served_floor, 7'b0001000);
        chk("t2_served_updn", {bus.served_up, bus.served_dn}, 2'b10);
        bus.up_passenger = 7'd0;
        @(negedge clk);
        chk("t2_pulse_1cyc", {bus.served_floor, bus.served_up}, 8'd0);
        measure(2, 40, n);
        chk("t2_door_cycles", n + 1, 4);
        chk("t2_idle_after", {bus.moving_up, bus.moving_down, bus.door_open}, 3'b000);

        // ---- 3: car_dest 6 plus down call at 3: pass 3, stop 6, come back to 3
        do_reset();
        bus.car_dest       = 7'b0100000;
        bus.down_passenger = 7'b0000100;
        wait_high(0, 5, w);
        measure(0, 100, n);
        chk("t3_up_cycles", n, 40);
        chk("t3_floor6", bus.cur_floor, 3'd6);
        chk("t3_served6", {bus.served_floor, bus.served_up, bus.served_dn}, {7'b0100000, 2'b00});
        bus.car_dest = 7'd0;
        measure(2, 40, n);
        chk("t3_door6_cycles", n, 4);
        wait_high(1, 5, w);
        chk("t3_down_latency", w, 1);
        measure(1, 100, n);
        chk("t3_down_cycles", n, 24);
        chk("t3_floor3", bus.cur_floor, 3'd3);
        chk("t3_served3", {bus.served_floor, bus.served_up, bus.served_dn}, {7'b0000100, 2'b01});
        bus.down_passenger = 7'd0;

        // ---- 4: to floor 7, door held, then destination floor 1
        do_reset();
        bus.car_dest  = 7'b1000000;
        bus.door_hold = 1'b1;
        wait_high(0, 5, w);
        measure(0, 100, n);
        chk("t4_up_cycles", n, 48);
        chk("t4_floor7", bus.cur_floor, 3'd7);
        chk("t4_served7", {bus.served_floor, bus.served_up, bus.served_dn}, {7'b1000000, 2'b00});
        bus.car_dest = 7'b0000001;
        // hold stays high until the falling edge of the 10th door cycle:
        // 9 reloads of the 4-cycle dwell -> 9 + 4 = 13 cycles open
        n = 0;
        while (bus.door_open && n < 60) begin
            n++;
            if (n == 10) bus.door_hold = 1'b0;
            @(negedge clk);
        end
        chk("t4_door_hold_cycles", n, 13);
        wait_high(1, 5, w);
        measure(1, 100, n);
        chk("t4_down_cycles", n, 48);
        chk("t4_floor1", bus.cur_floor, 3'd1);
        chk("t4_served1", {bus.served_floor, bus.served_up, bus.served_dn}, {7'b0000001, 2'b00});
        bus.car_dest = 7'd0;

        // ---- 5: up call at 5 withdrawn during the first floor of travel
        do_reset();
        bus.up_passenger = 7'b0010000;
        wait_high(0, 5, w);
        n = 0;
        while (bus.moving_up && n < 100) begin
            n++;
            if (n == 4) bus.up_passenger = 7'd0;
            @(negedge clk);
        end
        chk("t5_move_cycles", n, 8);
        chk("t5_floor2", bus.cur_floor, 3'd2);
        bad = 1'b0;
        repeat (20) begin
            if (bus.door_open || bus.moving_up || bus.moving_down || bus.served_floor != 7'd0)
                bad = 1'b1;
            @(negedge clk);
        end
        chk("t5_no_door", bad, 1'b0);
        chk("t5_still_floor2", bus.cur_floor, 3'd2);

        // ---- 6: idle at floor 4 (park behaviour depends on build)
        do_reset();
        bus.car_dest = 7'b0001000;
        wait_high(0, 5, w);
        measure(0, 100, n);
        chk("t6_floor4", bus.cur_floor, 3'd4);
        bus.car_dest = 7'd0;
        measure(2, 40, n);
`ifdef PARK_HOME_EN
        n = 0;
        while (!bus.moving_down && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("t6_park_idle_cycles", n, 16);
        measure(1, 100, n);
        chk("t6_park_down_cycles", n, 24);
        chk("t6_park_floor1", bus.cur_floor, 3'd1);
        bad = 1'b0;
        repeat (10) begin
            if (bus.door_open || bus.moving_up || bus.moving_down || bus.served_floor != 7'd0)
                bad = 1'b1;
            @(negedge clk);
        end
        chk("t6_park_quiet", bad, 1'b0);
`else
        bad = 1'b0;
        repeat (40) begin
            if (bus.door_open || bus.moving_up || bus.moving_down || bus.cur_floor != 3'd4)
                bad = 1'b1;
            @(negedge clk);
        end
        chk("t6_stays_floor4", bad, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
